// File: rtl/dec_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module   : dec_rr_sel
//  Purpose  : Multi-channel W-bit code decoder with a registered one-hot
//             output. The source channel is either taken from a fixed
//             select input or found by round-robin scanning over the
//             enabled channels.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W     code width per channel; result is 2**W bits wide
//    N     number of channels, 2 <= N <= 2**SELW
//    SELW  width of the channel-index signals
//  Ports
//    clk     in   1         rising-edge clock
//    rst     in   1         synchronous active-high reset
//    code    in   N*W       channel codes, channel i at [i*W +: W]
//    en      in   N         per-channel enables
//    mode    in   1         0 = fixed select, 1 = round-robin
//    sel     in   SELW      channel index used in fixed mode
//    result  out  2**W      registered one-hot decode, or zero
//    chan    out  SELW      registered index of the source channel
//    valid   out  1         registered; result holds a decoded code
// ============================================================================
module dec_rr_sel #(
  parameter int W    = 2,
  parameter int N    = 2,
  parameter int SELW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*W-1:0]      code,
  input  logic [N-1:0]        en,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [(2**W)-1:0]   result,
  output logic [SELW-1:0]     chan,
  output logic                valid
);

  localparam int OW = 2**W;

  // Last round-robin grant; reset value N-1 makes the first scan start at 0.
  localparam logic [SELW-1:0] PTR_RST = SELW'(N-1);

  logic [OW-1:0]   result_q, result_d;
  logic [SELW-1:0] chan_q,   chan_d;
  logic            valid_q,  valid_d;
  logic [SELW-1:0] ptr_q,    ptr_d;

  // Fixed-mode channel lookup
  logic            fix_hit;
  logic            fix_en;
  logic [W-1:0]    fix_code;

  // Round-robin grant search
  logic            hi_found;
  logic [SELW-1:0] hi_idx;
  logic            lo_found;
  logic [SELW-1:0] lo_idx;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic [W-1:0]    rr_code;

  function automatic logic [OW-1:0] onehot(input logic [W-1:0] c);
    logic [OW-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Fixed mode: a sel value with no matching channel (sel >= N) never hits,
  // so out-of-range selects decode to an invalid, all-zero result.
  always_comb begin
    fix_hit  = 1'b0;
    fix_en   = 1'b0;
    fix_code = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        fix_hit  = 1'b1;
        fix_en   = en[i];
        fix_code = code[i*W +: W];
      end
    end
  end

  // Round-robin: scanning ptr+1 .. ptr+N modulo N is equivalent to taking
  // the lowest enabled channel above ptr, else the lowest enabled channel
  // at or below ptr (ptr itself is therefore visited last).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        if (SELW'(i) > ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = SELW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = SELW'(i);
        end
      end
    end
    rr_found = hi_found | lo_found;
    rr_idx   = hi_found ? hi_idx : lo_idx;

    rr_code = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_idx == SELW'(i)) begin
        rr_code = code[i*W +: W];
      end
    end
  end

  // Next-state selection
  always_comb begin
    result_d = result_q;
    chan_d   = chan_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    if (!mode) begin
      chan_d = sel;
      if (fix_hit && fix_en) begin
        result_d = onehot(fix_code);
        valid_d  = 1'b1;
      end else begin
        result_d = '0;
        valid_d  = 1'b0;
      end
    end else if (rr_found) begin
      result_d = onehot(rr_code);
      chan_d   = rr_idx;
      valid_d  = 1'b1;
      ptr_d    = rr_idx;
    end else begin
      // Nothing enabled: chan and ptr keep their last grant.
      result_d = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= PTR_RST;
    end else begin
      result_q <= result_d;
      chan_q   <= chan_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
    end
  end

  assign result = result_q;
  assign chan   = chan_q;
  assign valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_rr_sel
//  Purpose  : Directed self-checking bench for dec_rr_sel, covering the
//             default N=2/W=2 configuration and an N=4/W=3 configuration.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dec_rr_sel;

  logic clk;

  // Configuration A: N=2, W=2, SELW=1
  logic        rst_a;
  logic [3:0]  code_a;
  logic [1:0]  en_a;
  logic        mode_a;
  logic [0:0]  sel_a;
  logic [3:0]  result_a;
  logic [0:0]  chan_a;
  logic        valid_a;

  // Configuration B: N=4, W=3, SELW=2
  logic        rst_b;
  logic [11:0] code_b;
  logic [3:0]  en_b;
  logic        mode_b;
  logic [1:0]  sel_b;
  logic [7:0]  result_b;
  logic [1:0]  chan_b;
  logic        valid_b;

  int checks = 0;
  int errors = 0;

  dec_rr_sel #(.W(2), .N(2), .SELW(1)) u_dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .code   (code_a),
    .en     (en_a),
    .mode   (mode_a),
    .sel    (sel_a),
    .result (result_a),
    .chan   (chan_a),
    .valid  (valid_a)
  );

  dec_rr_sel #(.W(3), .N(4), .SELW(2)) u_dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .code   (code_b),
    .en     (en_b),
    .mode   (mode_b),
    .sel    (sel_b),
    .result (result_b),
    .chan   (chan_b),
    .valid  (valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] r, input logic c, input logic v);
    check({tag, ".result"}, 32'(result_a), 32'(r));
    check({tag, ".chan"},   32'(chan_a),   32'(c));
    check({tag, ".valid"},  32'(valid_a),  32'(v));
  endtask

  task automatic check_b(input string tag, input logic [7:0] r, input logic [1:0] c, input logic v);
    check({tag, ".result"}, 32'(result_b), 32'(r));
    check({tag, ".chan"},   32'(chan_b),   32'(c));
    check({tag, ".valid"},  32'(valid_b),  32'(v));
  endtask

  initial begin
    rst_a = 1'b1; code_a = 4'b10_00; en_a = 2'b00; mode_a = 1'b0; sel_a = 1'b0;
    rst_b = 1'b1; code_b = 12'b111_000_101_011; en_b = 4'b0000; mode_b = 1'b0; sel_b = 2'd0;

    // Reset state
    tick();
    tick();
    check_a("a_reset", 4'b0000, 1'b0, 1'b0);
    check_b("b_reset", 8'h00, 2'd0, 1'b0);

    // 1. Fixed mode
    rst_a = 1'b0; mode_a = 1'b0; sel_a = 1'b1; en_a = 2'b10;
    tick(); check_a("fix_sel1_en10", 4'b0100, 1'b1, 1'b1);
    en_a = 2'b00;
    tick(); check_a("fix_sel1_en00", 4'b0000, 1'b1, 1'b0);
    sel_a = 1'b0;
    tick(); check_a("fix_sel0_en00", 4'b0000, 1'b0, 1'b0);
    en_a = 2'b01;
    tick(); check_a("fix_sel0_en01", 4'b0001, 1'b0, 1'b1);

    // 2. Round-robin from reset, both enabled
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; mode_a = 1'b1; en_a = 2'b11;
    tick(); check_a("rr11_g0", 4'b0001, 1'b0, 1'b1);
    tick(); check_a("rr11_g1", 4'b0100, 1'b1, 1'b1);
    tick(); check_a("rr11_g2", 4'b0001, 1'b0, 1'b1);
    tick(); check_a("rr11_g3", 4'b0100, 1'b1, 1'b1);

    // 3. Single enabled channel, including grant equal to ptr
    en_a = 2'b10;
    tick(); check_a("rr10_a", 4'b0100, 1'b1, 1'b1);
    tick(); check_a("rr10_b", 4'b0100, 1'b1, 1'b1);
    en_a = 2'b00;
    tick(); check_a("rr00_hold", 4'b0000, 1'b1, 1'b0);

    // 4. Reset mid-scan discards ptr
    en_a = 2'b11;
    tick(); check_a("rr_pre_rst", 4'b0001, 1'b0, 1'b1);
    rst_a = 1'b1;
    tick(); check_a("rr_mid_rst", 4'b0000, 1'b0, 1'b0);
    rst_a = 1'b0;
    tick(); check_a("rr_post_rst", 4'b0001, 1'b0, 1'b1);

    // 5. Mode interleave keeps ptr (last grant was ch0)
    mode_a = 1'b0; sel_a = 1'b1; en_a = 2'b11;
    tick(); check_a("ilv_fix0", 4'b0100, 1'b1, 1'b1);
    tick(); check_a("ilv_fix1", 4'b0100, 1'b1, 1'b1);
    tick(); check_a("ilv_fix2", 4'b0100, 1'b1, 1'b1);
    mode_a = 1'b1;
    tick(); check_a("ilv_rr_resume", 4'b0100, 1'b1, 1'b1);
    tick(); check_a("ilv_rr_next", 4'b0001, 1'b0, 1'b1);

    // 6. N=4, W=3 round-robin with a gap and wrap-around
    rst_b = 1'b0; mode_b = 1'b1; en_b = 4'b1011;
    tick(); check_b("b_rr_ch0", 8'b0000_1000, 2'd0, 1'b1);
    tick(); check_b("b_rr_ch1", 8'b0010_0000, 2'd1, 1'b1);
    tick(); check_b("b_rr_ch3", 8'b1000_0000, 2'd3, 1'b1);
    tick(); check_b("b_rr_wrap", 8'b0000_1000, 2'd0, 1'b1);
    mode_b = 1'b0; sel_b = 2'd2;
    tick(); check_b("b_fix_sel2_off", 8'h00, 2'd2, 1'b0);
    sel_b = 2'd3;
    tick(); check_b("b_fix_sel3", 8'b1000_0000, 2'd3, 1'b1);
    mode_b = 1'b1;
    tick(); check_b("b_rr_resume", 8'b0010_0000, 2'd1, 1'b1);

    // Code and enable changing together: only the sampled values count
    code_b = 12'b111_010_101_011; en_b = 4'b0100;
    tick(); check_b("b_rr_newcode", 8'b0000_0100, 2'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
